// File: rtl/avr_pin_input_pkg.sv
// Shared SoC I/O constants for the pin input block: register addresses, edge-select
// encodings and the debounce default.
package avr_pin_input_pkg;

  localparam logic [7:0] PINB_ADDR  = 8'h03;
  localparam logic [7:0] DDRB_ADDR  = 8'h04;
  localparam logic [7:0] PORTB_ADDR = 8'h05;
  localparam logic [7:0] PCIFR_ADDR = 8'h1b;
  localparam logic [7:0] PCMSK_ADDR = 8'h6b;

  localparam logic [1:0] EDGE_ANY  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;

  localparam int unsigned DEBOUNCE_DEFAULT = 4;

  // 2'b11 is treated like EDGE_ANY.
  function automatic logic edge_match(logic [1:0] sel, logic new_level);
    logic match;
    match = 1'b1;
    if (sel == EDGE_RISE) begin
      match = new_level;
    end else if (sel == EDGE_FALL) begin
      match = !new_level;
    end
    return match;
  endfunction

endpackage

// File: rtl/avr_pin_input_if.sv
// Pad, mask, flag-control and status signals of the pin input block.
interface avr_pin_input_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] pad_in;
  logic [WIDTH-1:0] pc_mask;
  logic [1:0]       edge_sel;
  logic             flag_clr;
  logic [WIDTH-1:0] flag_clr_bits;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] pc_flag;
  logic             irq;

  modport master (
    output pad_in, pc_mask, edge_sel, flag_clr, flag_clr_bits,
    input  pin, pc_flag, irq
  );

  modport slave (
    input  pad_in, pc_mask, edge_sel, flag_clr, flag_clr_bits,
    output pin, pc_flag, irq
  );

endinterface

// File: rtl/avr_pin_input_pin_debounce.sv
// One-bit pad conditioner: two-flop synchronizer, stability counter and stable level.
// accept_o is high in the cycle whose closing edge flips level_o.
module pin_debounce
  import avr_pin_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pad_i,
  output logic level_o,
  output logic accept_o
);

  localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);

  logic            s1_q, s2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    accept  = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = s2_q;
      cnt_d   = '0;
      accept  = 1'b1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= pad_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o  = level_q;
  assign accept_o = accept;

endmodule

// File: rtl/avr_pin_input.sv
// GPIO input side: per-pin debounce plus sticky, masked, edge-selected pin-change flags
// with write-1-to-clear and an OR'd interrupt.
module avr_pin_input
  import avr_pin_input_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  avr_pin_input_if.slave bus
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] set_bits;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] flag_q, flag_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    pin_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
      .clk_i   (clk),
      .rst_ni  (reset),
      .pad_i   (bus.pad_in[i]),
      .level_o (level[i]),
      .accept_o(accept[i])
    );
  end

  // On accept the new level is the inverse of the current one.
  always_comb begin
    set_bits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      set_bits[i] = accept[i] & bus.pc_mask[i] & edge_match(bus.edge_sel, !level[i]);
    end
    clr_bits = bus.flag_clr ? bus.flag_clr_bits : '0;
    flag_d   = (flag_q & ~clr_bits) | set_bits;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_q <= '0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign bus.pin     = level;
  assign bus.pc_flag = flag_q;
  assign bus.irq     = |flag_q;

endmodule

// File: tb/tb_avr_pin_input.sv
// Randomized and directed bench for avr_pin_input against a history-window reference model.
module tb_avr_pin_input;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  avr_pin_input_if #(.WIDTH(W)) bus ();

  avr_pin_input #(
    .WIDTH   (W),
    .DEBOUNCE(D)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Reference: pin[i] flips when the last D values seen by the second sync stage all
  // differ from it; the second stage sees the pad value from two edges earlier.
  logic [W-1:0] pin_m  = '0;
  logic [W-1:0] flag_m = '0;
  logic [W-1:0] hist[$];
  logic [W-1:0] acc_m;
  logic [W-1:0] set_m;
  logic         diff_all;
  int           sz;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pin_m  = '0;
      flag_m = '0;
      hist   = {W'(0), W'(0)};
    end else begin
      acc_m = '0;
      set_m = '0;
      sz    = hist.size();
      for (int i = 0; i < W; i++) begin
        if (sz >= D + 1) begin
          diff_all = 1'b1;
          for (int j = 0; j < D; j++) begin
            if (hist[sz-2-j][i] == pin_m[i]) diff_all = 1'b0;
          end
          acc_m[i] = diff_all;
        end
        if (acc_m[i] && bus.pc_mask[i]) begin
          // New level is !pin_m[i].
          if (bus.edge_sel == 2'b01)      set_m[i] = !pin_m[i];
          else if (bus.edge_sel == 2'b10) set_m[i] = pin_m[i];
          else                            set_m[i] = 1'b1;
        end
      end
      pin_m = pin_m ^ acc_m;
      if (bus.flag_clr) flag_m = flag_m & ~bus.flag_clr_bits;
      flag_m = flag_m | set_m;
      hist.push_back(bus.pad_in);
      if (hist.size() > D + 4) void'(hist.pop_front());
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_eq("pin", 32'(bus.pin), 32'(pin_m));
    check_eq("pc_flag", 32'(bus.pc_flag), 32'(flag_m));
    check_eq("irq", 32'(bus.irq), 32'(|flag_m));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_flags(input logic [W-1:0] bits);
    bus.flag_clr      = 1'b1;
    bus.flag_clr_bits = bits;
    tick();
    bus.flag_clr      = 1'b0;
    bus.flag_clr_bits = '0;
  endtask

  // Edges from the capture edge until bit b of pin reads 1.
  task automatic measure_latency(input string tag, input int b);
    int n;
    n = 0;
    while (n < 20 && bus.pin[b] !== 1'b1) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(n - 1), 32'(D + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset             = 1'b0;
    bus.pad_in        = '0;
    bus.pc_mask       = '0;
    bus.edge_sel      = 2'b00;
    bus.flag_clr      = 1'b0;
    bus.flag_clr_bits = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_pin", 32'(bus.pin), 32'h0);
    check_eq("reset_irq", 32'(bus.irq), 32'h0);
    reset = 1'b1;

    ticks(20);
    check_eq("idle_pin", 32'(bus.pin), 32'h0);

    bus.pc_mask = 8'hff;
    bus.pad_in  = 8'h01;
    measure_latency("lat_bit0", 0);
    check_eq("step_flag0", 32'(bus.pc_flag), 32'h01);
    check_eq("step_irq", 32'(bus.irq), 32'h1);

    bus.pad_in[3] = 1'b1;
    ticks(3);
    bus.pad_in[3] = 1'b0;
    ticks(10);
    check_eq("glitch_pin3", 32'(bus.pin[3]), 32'h0);
    check_eq("glitch_flag3", 32'(bus.pc_flag[3]), 32'h0);
    bus.pad_in[3] = 1'b1;
    ticks(10);
    check_eq("hold_pin3", 32'(bus.pin[3]), 32'h1);
    check_eq("hold_flag3", 32'(bus.pc_flag[3]), 32'h1);

    clear_flags(8'hff);
    bus.edge_sel  = 2'b01;
    bus.pad_in[5] = 1'b1;
    ticks(10);
    check_eq("rise_flag5", 32'(bus.pc_flag[5]), 32'h1);
    clear_flags(8'h20);
    bus.pad_in[5] = 1'b0;
    ticks(10);
    check_eq("fall_flag5", 32'(bus.pc_flag[5]), 32'h0);

    bus.pc_mask  = 8'h00;
    bus.edge_sel = 2'b00;
    clear_flags(8'hff);
    for (int k = 0; k < 4; k++) begin
      bus.pad_in = ~bus.pad_in;
      ticks(8);
      check_eq("nomask_pin", 32'(bus.pin), 32'(bus.pad_in));
    end
    bus.pad_in = 8'h00;
    ticks(8);
    check_eq("nomask_flag", 32'(bus.pc_flag), 32'h0);

    bus.pc_mask   = 8'hff;
    bus.pad_in[2] = 1'b1;
    ticks(5);
    clear_flags(8'h04);
    check_eq("setwins_flag2", 32'(bus.pc_flag[2]), 32'h1);

    clear_flags(8'hff);
    bus.pad_in[4] = 1'b1;
    ticks(3);
    #1 reset = 1'b0;
    #1;
    check_eq("midrst_pin", 32'(bus.pin), 32'h0);
    check_eq("midrst_flag", 32'(bus.pc_flag), 32'h0);
    check_eq("midrst_irq", 32'(bus.irq), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    measure_latency("lat_bit4", 4);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) == 0) bus.pad_in = bus.pad_in ^ W'($urandom);
      if ($urandom_range(0, 19) == 0) bus.pc_mask = W'($urandom);
      if ($urandom_range(0, 29) == 0) bus.edge_sel = 2'($urandom);
      bus.flag_clr      = ($urandom_range(0, 9) == 0);
      bus.flag_clr_bits = W'($urandom);
      tick();
    end
    bus.flag_clr = 1'b0;
    ticks(10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/avr_pin_input.md
# avr_pin_input

Input-side GPIO block for the AVR SoC: conditions asynchronous external pads into the `pin_b` value the CPU reads, and raises pin-change interrupt flags. Each bit is double-flop synchronized, then debounced by a per-bit stability counter. Debounced edges set sticky, write-1-to-clear flags gated by a mask. It sits between the top-level pads and the SoC's `pin_b`, `pcmsk`, `pcifr` and `irq` hookup.

## Interface
- `WIDTH`, 8: number of pins.
- `DEBOUNCE`, 4: consecutive synchronized cycles a new level must hold before `pin` accepts it. Must be ≥ 1; 1 means synchronizer only.
- `clk  input  1`: system clock, the CPU clock.
- `reset  input  1`: asynchronous, active-low reset.
- `pad_in  input  WIDTH`: raw asynchronous pad levels.
- `pc_mask  input  WIDTH`: per-bit enable for flag setting.
- `edge_sel  input  2`: edge that sets a flag.
  - 00 and 11: any edge.
  - 01: rising edge only.
  - 10: falling edge only.
- `flag_clr  input  1`: one-cycle strobe that clears flags.
- `flag_clr_bits  input  WIDTH`: bits cleared when `flag_clr` is high (write-1-to-clear).
- `pin  output  WIDTH`: debounced, registered pin levels.
- `pc_flag  output  WIDTH`: sticky pin-change flags.
- `irq  output  1`: OR of `pc_flag`.

## Operation
- Per bit `i`, there is a two-stage synchronizer `s1`, `s2`, followed by a counter `cnt` and a stable register `pin[i]`.
- Counter rule, each edge:
  - If `s2 == pin[i]`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE-1`: `pin[i] <= s2` and `cnt <= 0`. This edge is the "accept" event.
  - Else: `cnt <= cnt + 1`.
- Counter width is `$clog2(DEBOUNCE)`, minimum 1. `cnt` never exceeds `DEBOUNCE-1`; there is no wrap.
- A glitch that holds the new level in `s2` for fewer than `DEBOUNCE` cycles leaves `pin` and `pc_flag` unchanged, and `cnt` returns to 0.
- Flag set on an accept event when `pc_mask[i]` is 1 and the edge matches `edge_sel`:
  - Rising means the new `pin[i]` is 1.
  - Falling means the new `pin[i]` is 0.
- Flags are sticky until cleared. A bit that is already set stays set.
- Clear: on `flag_clr` high, every bit with `flag_clr_bits[i]` = 1 is cleared.
- Set and clear of the same bit in the same cycle: set wins, and the flag remains 1.
- Changing `pc_mask` or `edge_sel` affects only future accept events; it never sets or clears existing flags.
- `irq` is combinational: `|pc_flag`.

## Timing
- Reset (`reset` low, asynchronous): `s1`, `s2`, `cnt`, `pin`, `pc_flag` all go to 0, and `irq` goes to 0.
- After release, a pad held at 1 is accepted through the normal debounce path and sets a flag if masked. This is intended.
- Latency: a pad change first sampled by `s1` at edge k updates `pin` at edge k+1+DEBOUNCE. With DEBOUNCE = 4, that is 5 edges after the capture edge.
- `pc_flag` updates on the same edge as `pin`, and `irq` follows in the same cycle.
- Reset asserted mid-debounce discards the in-progress count; no partial acceptance survives.
- All bits are independent. Simultaneous accepts on several bits set all matching flags on the same edge.
- Clear takes effect at the edge where `flag_clr` is sampled high; `irq` drops in the following cycle if no flags remain.

## Structure
- `avr_pin_input` instantiates `WIDTH` copies of `pin_debounce`.
  - `pin_debounce` is a one-bit sub-module containing the synchronizer, counter and stable register.
  - Its outputs are `level` and a one-cycle `accept` pulse.
- Flag, mask, edge-select and clear logic live in the parent.
- The edge-select encodings go in the shared SoC package beside the existing I/O register constants:
  - `EDGE_ANY`, 2'b00
  - `EDGE_RISE`, 2'b01
  - `EDGE_FALL`, 2'b10
- The DEBOUNCE default also goes in that package.

## Test plan
- Reset, then hold `pad_in` = 0 for 20 cycles: `pin` = 00, `pc_flag` = 00, `irq` = 0 throughout.
- With `pc_mask` = FF and `edge_sel` = 00, step `pad_in[0]` to 1: `pin` becomes 01 exactly 5 edges after capture, `pc_flag` = 01 on that same edge, and `irq` = 1.
- Pulse `pad_in[3]` high for 3 cycles: `pin` stays 00 and no flag is set. Then hold it high for 10 cycles: `pin[3]` = 1 and `pc_flag[3]` = 1.
- With `edge_sel` = 01, toggle `pad_in[5]` 0→1→0 with long holds: the flag sets on the rise only. Clear it with `flag_clr_bits` = 20, then confirm the fall does not re-set it.
- With `pc_mask` = 00, toggle all pins: `pin` follows the pads and `pc_flag` stays 00.
- Assert `flag_clr` for bit 2 on the same edge that bit 2 accepts a masked edge: `pc_flag[2]` = 1. Then assert reset mid-count on bit 4: all outputs go to 0 immediately, and bit 4 needs a full 5 edges after release to update.
